// File: rtl/compare_pkg.sv
// rtl/compare_pkg.sv - shared state encoding, geometry helpers and widths for the compare sequencer
package compare_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        ISSUE,
        WAIT_DONE,
        SCAN,
        EMIT
    } state_t;

    localparam int CNT_WIDTH = 16;
    localparam int SUM_WIDTH_DEFAULT = 16;

    function automatic int num_blocks(input int frame_width, input int block_size);
        return frame_width / block_size;
    endfunction

    function automatic int num_compares(input int frame_width, input int block_size,
                                        input int compare_step);
        return (frame_width - block_size) / compare_step + 1;
    endfunction

    function automatic int num_rows(input int frame_height, input int block_size);
        return frame_height / block_size;
    endfunction

endpackage

// File: rtl/argmin_scan.sv
// rtl/argmin_scan.sv - walks every compare index of one block and keeps the lowest-sum index
module argmin_scan #(
    parameter int NUM_COMPARES = 40,
    parameter int SUM_WIDTH    = 16,
    parameter int IDX_WIDTH    = 6
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [SUM_WIDTH-1:0] rd_data,
    output logic [IDX_WIDTH-1:0] sel,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_WIDTH-1:0] index
);

    localparam int CW = $clog2(NUM_COMPARES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_COMPARES);

    logic [CW-1:0]        cnt;
    logic [IDX_WIDTH-1:0] sel_d;
    logic [SUM_WIDTH-1:0] min_val;

    assign sel  = cnt[IDX_WIDTH-1:0];
    assign done = busy && (cnt == LAST);

    // cnt == k compares the sum addressed at k-1; cnt == 1 seeds the minimum
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            busy    <= 1'b0;
            cnt     <= '0;
            sel_d   <= '0;
            min_val <= '0;
            index   <= '0;
        end else begin
            sel_d <= sel;
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (busy) begin
                if (cnt != '0) begin
                    if (cnt == CW'(1) || rd_data < min_val) begin
                        min_val <= rd_data;
                        index   <= sel_d;
                    end
                end
                if (done) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/compare_sequencer.sv
// rtl/compare_sequencer.sv - sequences per-line block compares and per-row argmin readback for one frame
module compare_sequencer
    import compare_pkg::*;
#(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int BLOCK_SIZE   = 8,
    parameter int COMPARE_STEP = 8,
    parameter int SUM_WIDTH    = SUM_WIDTH_DEFAULT
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 line_valid,
    output logic                 line_ack,
    output logic                 cmp_go,
    output logic [CNT_WIDTH-1:0] cmp_block_count,
    output logic [CNT_WIDTH-1:0] cmp_line_count,
    input  logic                 cmp_done,
    output logic [$clog2(num_blocks(FRAME_WIDTH, BLOCK_SIZE))-1:0]                   sum_blk_sel,
    output logic [$clog2(num_compares(FRAME_WIDTH, BLOCK_SIZE, COMPARE_STEP))-1:0]   sum_cmp_sel,
    input  logic [SUM_WIDTH-1:0] sum_rd_data,
    output logic                 disp_valid,
    input  logic                 disp_ready,
    output logic [$clog2(num_blocks(FRAME_WIDTH, BLOCK_SIZE))-1:0]                   disp_block,
    output logic [$clog2(num_rows(FRAME_HEIGHT, BLOCK_SIZE))-1:0]                    disp_row,
    output logic [$clog2(num_compares(FRAME_WIDTH, BLOCK_SIZE, COMPARE_STEP))-1:0]   disp_index,
    output logic                 frame_done
);

    localparam int NUM_BLOCKS   = num_blocks(FRAME_WIDTH, BLOCK_SIZE);
    localparam int NUM_COMPARES = num_compares(FRAME_WIDTH, BLOCK_SIZE, COMPARE_STEP);
    localparam int NUM_ROWS     = num_rows(FRAME_HEIGHT, BLOCK_SIZE);
    localparam int BLK_W  = $clog2(NUM_BLOCKS);
    localparam int IDX_W  = $clog2(NUM_COMPARES);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int LINE_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(BLOCK_SIZE - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);

    state_t             state, state_next;
    logic [BLK_W-1:0]   blk;
    logic [LINE_W-1:0]  line;
    logic [ROW_W-1:0]   row;
    logic               armed;
    logic               scan_start, scan_busy, scan_done;
    logic               cmp_accept;

    // a done level only counts once it has been seen low after the go
    assign cmp_accept = armed && cmp_done;

    argmin_scan #(
        .NUM_COMPARES (NUM_COMPARES),
        .SUM_WIDTH    (SUM_WIDTH),
        .IDX_WIDTH    (IDX_W)
    ) u_argmin_scan (
        .aclk    (aclk),
        .aresetn (aresetn),
        .start   (scan_start),
        .rd_data (sum_rd_data),
        .sel     (sum_cmp_sel),
        .busy    (scan_busy),
        .done    (scan_done),
        .index   (disp_index)
    );

    assign sum_blk_sel     = blk;
    assign disp_block      = blk;
    assign disp_row        = row;
    assign disp_valid      = (state == EMIT);
    assign cmp_go          = (state == ISSUE);
    assign cmp_block_count = (state == ISSUE || state == WAIT_DONE) ? CNT_WIDTH'(blk)  : '0;
    assign cmp_line_count  = (state == ISSUE || state == WAIT_DONE) ? CNT_WIDTH'(line) : '0;

    always_comb begin
        state_next = state;
        line_ack   = 1'b0;
        scan_start = 1'b0;
        case (state)
            IDLE:      if (start) state_next = WAIT_LINE;
            WAIT_LINE: if (line_valid) state_next = ISSUE;
            ISSUE:     state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (cmp_accept) begin
                    if (blk != LAST_BLK) begin
                        state_next = ISSUE;
                    end else begin
                        line_ack = 1'b1;
                        if (line != LAST_LINE) begin
                            state_next = WAIT_LINE;
                        end else begin
                            state_next = SCAN;
                            scan_start = !scan_busy;
                        end
                    end
                end
            end
            SCAN:      if (scan_done) state_next = EMIT;
            EMIT: begin
                if (disp_ready) begin
                    if (blk != LAST_BLK) begin
                        state_next = SCAN;
                        scan_start = !scan_busy;
                    end else if (row != LAST_ROW) begin
                        state_next = WAIT_LINE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            blk        <= '0;
            line       <= '0;
            row        <= '0;
            armed      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        blk  <= '0;
                        line <= '0;
                        row  <= '0;
                    end
                end
                ISSUE: armed <= 1'b0;
                WAIT_DONE: begin
                    if (!cmp_done) armed <= 1'b1;
                    if (cmp_accept) begin
                        if (blk != LAST_BLK) begin
                            blk <= blk + 1'b1;
                        end else begin
                            blk  <= '0;
                            line <= (line != LAST_LINE) ? line + 1'b1 : '0;
                        end
                    end
                end
                EMIT: begin
                    if (disp_ready) begin
                        if (blk != LAST_BLK) begin
                            blk <= blk + 1'b1;
                        end else begin
                            blk <= '0;
                            if (row != LAST_ROW) begin
                                row <= row + 1'b1;
                            end else begin
                                row        <= '0;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/compare_sequencer.md
Name: compare_sequencer

Overview:
- Controls one block-matching comparator for one frame.
- For each line, issues one compare operation per block index, then releases the line buffer.
- After every BLOCK_SIZE lines, reads back the accumulated sums and finds the compare index with the minimum sum for each block.
- Emits one disparity result per block on a valid/ready stream. Sits between the line/block buffer manager and the downstream disparity-map writer.

Parameters:
- FRAME_WIDTH, 320, pixels per line.
- FRAME_HEIGHT, 240, lines per frame; must be a multiple of BLOCK_SIZE.
- BLOCK_SIZE, 8, block edge in pixels.
- COMPARE_STEP, 8, pixel offset between candidate positions.
- SUM_WIDTH, 16, width of each comparator sum.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins a frame; ignored unless IDLE.
- line_valid  in  1  buffer manager has the current line and block data loaded.
- line_ack  out  1  one-cycle pulse: all blocks of the current line are compared, so the buffer may advance.
- cmp_go  out  1  one-cycle start pulse to the comparator.
- cmp_block_count  out  16  block index presented to the comparator.
- cmp_line_count  out  16  line index within the current block row (0..BLOCK_SIZE-1).
- cmp_done  in  1  comparator done level.
- sum_blk_sel  out  $clog2(NUM_BLOCKS)  sum read address, block index.
- sum_cmp_sel  out  $clog2(NUM_COMPARES)  sum read address, compare index.
- sum_rd_data  in  SUM_WIDTH  sum at the selected address; valid 1 cycle after the address is driven.
- disp_valid  out  1  disparity result valid.
- disp_ready  in  1  downstream accepts the result.
- disp_block  out  $clog2(NUM_BLOCKS)  block index of the result.
- disp_row  out  $clog2(NUM_ROWS)  block-row index of the result.
- disp_index  out  $clog2(NUM_COMPARES)  compare index with the minimum sum.
- frame_done  out  1  one-cycle pulse after the last result of the frame is accepted.

Behaviour:
- Derived constants:
  - NUM_BLOCKS = FRAME_WIDTH/BLOCK_SIZE.
  - NUM_COMPARES = (FRAME_WIDTH-BLOCK_SIZE)/COMPARE_STEP+1.
  - NUM_ROWS = FRAME_HEIGHT/BLOCK_SIZE.
- Reset values:
  - All outputs 0. State IDLE. Block, line, row and scan counters 0.
  - Reset asserted mid-operation aborts immediately. No line_ack, disp_valid or frame_done follows.
- States: IDLE, WAIT_LINE, ISSUE, WAIT_DONE, SCAN, EMIT.
- IDLE: on start go to WAIT_LINE. Clear row, line and block counters.
- WAIT_LINE: wait for line_valid=1, then go to ISSUE.
- ISSUE: for exactly one cycle:
  - cmp_go=1, cmp_block_count=block counter, cmp_line_count=line counter.
  - Clear the armed flag. Go to WAIT_DONE.
- WAIT_DONE:
  - Set armed on the first cycle cmp_done=0. A stale done level from the previous operation is never accepted.
  - Complete when armed=1 and cmp_done=1. Then:
    - If block < NUM_BLOCKS-1: increment block, go to ISSUE. The next cmp_go comes 1 cycle after done is accepted.
    - Otherwise: pulse line_ack and set block=0.
      - If line < BLOCK_SIZE-1: increment line, go to WAIT_LINE.
      - Otherwise: set line=0, go to SCAN.
- cmp_block_count and cmp_line_count hold their values from ISSUE through WAIT_DONE.
- SCAN: for each compare index c = 0..NUM_COMPARES-1 of the current block:
  - Drive the address every cycle.
  - Compare the returned data 1 cycle later, unsigned.
  - A strict "<" replaces the current minimum. Ties keep the lowest index.
  - The first returned sum initialises the minimum unconditionally.
  - Scan length per block: NUM_COMPARES+1 cycles.
  - Then go to EMIT.
- EMIT:
  - disp_valid=1 with disp_block, disp_row and disp_index stable until disp_ready=1.
  - After the handshake:
    - If the block is not the last: next block, back to SCAN.
    - Else if the row is not the last: increment row, set block=0, go to WAIT_LINE.
    - Else: pulse frame_done, go to IDLE.
  - disp_ready already high when valid rises completes in that cycle.
- line_valid is sampled only in WAIT_LINE. start is ignored outside IDLE.
- All wraps are explicit compares. No counter is allowed to overflow.

Decomposition:
- compare_pkg holds:
  - the state enum;
  - the NUM_BLOCKS, NUM_COMPARES, NUM_ROWS derivation functions;
  - the width constants shared with the comparator.
- One sub-module, argmin_scan. It contains the compare-address counter, the one-cycle-delayed compare, and the running minimum value and index, with start/busy/done and index outputs. It is instantiated once, in SCAN.

Test Plan:
Small configuration for all scenarios: FRAME_WIDTH=32, FRAME_HEIGHT=16, BLOCK_SIZE=8, COMPARE_STEP=8, giving 4 blocks, 4 compares and 2 rows.
- Full frame, comparator model with done 3 cycles after go, sum model sum[b][c]=(c==b)?5:100 -> 64 cmp_go pulses; 16 line_ack pulses; 8 results in the order (row,block) = (0,0)..(1,3) with disp_index equal to the block; 1 frame_done.
- Stale done: cmp_done held high in IDLE and before the first go -> no advance until done falls then rises; exactly 1 go per block.
- Ties: sums {7,3,3,9} -> disp_index=1. Sums all 0 -> disp_index=0.
- Backpressure: disp_ready low for 10 cycles -> disp_valid held and payload stable; no SCAN progress; results not lost.
- Reset mid-frame: aresetn low during WAIT_DONE of line 3 -> next cycle all outputs 0, state IDLE; a later start restarts at row 0, line 0, block 0.
- start pulsed during ISSUE and EMIT -> ignored; the frame completes with the normal counts.
